// File: rtl/dmem_arbiter.sv
// Two-port arbiter that serialises byte/word accesses onto a byte-wide, strobe-edge-triggered data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 always wins ties.
module dmem_arbiter #(
  parameter int N      = 32,
  parameter int MEM_AW = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         we0,
  input  logic         byte0,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] wdata0,
  output logic         ack0,
  output logic [N-1:0] rdata0,
  input  logic         req1,
  input  logic         we1,
  input  logic         byte1,
  input  logic [N-1:0] addr1,
  input  logic [N-1:0] wdata1,
  output logic         ack1,
  output logic [N-1:0] rdata1,
  output logic         busy,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_re,
  output logic         mem_we,
  output logic         mem_isbyte
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        i_q, i_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       result_q, result_d;
  logic [N-1:0]      rdata0_q, rdata0_d;
  logic [N-1:0]      rdata1_q, rdata1_d;
  logic              win;
  logic              last_byte;
  logic              unused_inputs;

  assign unused_inputs = ^{addr0[N-1:MEM_AW], addr1[N-1:MEM_AW], mem_rdata[N-1:8]};

`ifdef DMEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (req0 && req1) win = ~last_grant_q;
    else              win = ~req0;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && (req0 || req1)) last_grant_d = win;
  end

  // Reset value 1 makes port 0 the winner of the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`else
  assign win = ~req0;
`endif

  assign last_byte = byte_q | (i_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    grant_d  = grant_q;
    we_d     = we_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d  = STROBE;
          i_d      = '0;
          grant_d  = win;
          result_d = '0;
          we_d     = win ? we1 : we0;
          byte_d   = win ? byte1 : byte0;
          addr_d   = win ? addr1[MEM_AW-1:0] : addr0[MEM_AW-1:0];
          wdata_d  = win ? wdata1[31:0] : wdata0[31:0];
        end
      end
      STROBE: state_d = CAPTURE;
      CAPTURE: begin
        if (!we_q) result_d[{i_q, 3'b000} +: 8] = mem_rdata[7:0];
        if (last_byte) begin
          state_d = DONE;
          // Load the port's read register on entry to DONE so it is valid during ack.
          if (grant_q) begin
            rdata1_d       = '0;
            rdata1_d[31:0] = we_q ? 32'd0 : result_d;
          end else begin
            rdata0_d       = '0;
            rdata0_d[31:0] = we_q ? 32'd0 : result_d;
          end
        end else begin
          state_d = STROBE;
          i_d     = i_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == STROBE) begin
      mem_re                = ~we_q;
      mem_we                = we_q;
      mem_addr[MEM_AW-1:0]  = addr_q + MEM_AW'(i_q);
      mem_wdata[7:0]        = wdata_q[{i_q, 3'b000} +: 8];
    end
    ack0 = (state_q == DONE) & ~grant_q;
    ack1 = (state_q == DONE) & grant_q;
    busy = (state_q != IDLE);
  end

  assign mem_isbyte = 1'b1;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-wide strobe-registered memory model and strobe log.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, byte0, req1, we1, byte1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, busy, mem_re, mem_we, mem_isbyte;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;
  int mon_errs = 0;

  logic [7:0]  mem [0:4095];
  logic [11:0] log_addr [0:255];
  logic [7:0]  log_data [0:255];
  logic        log_we   [0:255];
  int          log_n = 0;
  int          base;
  bit          prev_strobe = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.N(32), .MEM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .byte0(byte0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .byte1(byte1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_isbyte(mem_isbyte)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:0]] <= mem_wdata[7:0];
    if (mem_re) mem_rdata <= {24'd0, mem[mem_addr[11:0]]};
    if (mem_re || mem_we) begin
      log_addr[log_n] = mem_addr[11:0];
      log_data[log_n] = mem_wdata[7:0];
      log_we[log_n]   = mem_we;
      log_n++;
    end
  end

  always @(negedge clk) begin
    if ((mem_re || mem_we) && prev_strobe) begin
      mon_errs++;
      $error("FAIL back_to_back_strobe observed=1 expected=0 at %0t", $time);
    end
    if ((mem_re || mem_we || ack0 || ack1) && !busy) begin
      mon_errs++;
      $error("FAIL busy_while_active observed=0 expected=1 at %0t", $time);
    end
    prev_strobe = mem_re | mem_we;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit port, input bit w, input bit bt, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd,
                        input string tag);
    int lat;
    bit got;
    @(negedge clk);
    base = log_n;
    if (port) begin req1 = 1; we1 = w; byte1 = bt; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1; we0 = w; byte0 = bt; addr0 = a; wdata0 = wd; end
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      if (lat == 1) begin
        #1;
        if (port) begin we1 = ~w; byte1 = ~bt; addr1 = ~a; wdata1 = ~wd; end
        else      begin we0 = ~w; byte0 = ~bt; addr0 = ~a; wdata0 = ~wd; end
      end
      @(negedge clk);
      if ((port ? ack1 : ack0) === 1'b1) got = 1;
      else check({tag, " busy"}, busy, 1);
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, port ? rdata1 : rdata0, exp_rd);
    check({tag, " other_ack"}, port ? ack0 : ack1, 0);
    if (port) req1 = 0; else req0 = 0;
    @(negedge clk);
    check({tag, " ack_pulse"}, port ? ack1 : ack0, 0);
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " rdata_hold"}, port ? rdata1 : rdata0, exp_rd);
  endtask

  initial begin
    int n;
    int cyc;
    bit seq [0:3];
    logic [11:0] exp_a [0:3];
    logic [7:0]  exp_d [0:3];

    rst_n = 0;
    req0 = 0; we0 = 0; byte0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; byte1 = 0; addr1 = 0; wdata1 = 0;
    #1;
    req0 = 1;
    repeat (2) @(negedge clk);
    check("rst ack0", ack0, 0);
    check("rst ack1", ack1, 0);
    check("rst rdata0", rdata0, 0);
    check("rst rdata1", rdata1, 0);
    check("rst busy", busy, 0);
    check("rst strobes", {mem_re, mem_we}, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst isbyte", mem_isbyte, 1);
    req0 = 0;
    rst_n = 1;

    access(0, 1, 1, 32'h64, 32'hFFFF_FFA5, 3, 32'h0, "bw0");
    check("bw0 nstrobe", log_n - base, 1);
    check("bw0 addr", log_addr[base], 12'h064);
    check("bw0 data", log_data[base], 8'hA5);
    check("bw0 we", log_we[base], 1);

    access(0, 0, 1, 32'h64, 32'h0, 3, 32'h0000_00A5, "br0");
    check("br0 nstrobe", log_n - base, 1);
    check("br0 addr", log_addr[base], 12'h064);
    check("br0 we", log_we[base], 0);

    access(1, 1, 0, 32'h10, 32'h1122_3344, 9, 32'h0, "ww1");
    check("ww1 nstrobe", log_n - base, 4);
    exp_d = '{8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ww1 addr%0d", k), log_addr[base + k], 12'h010 + 12'(k));
      check($sformatf("ww1 data%0d", k), log_data[base + k], exp_d[k]);
    end

    access(1, 0, 0, 32'h10, 32'h0, 9, 32'h1122_3344, "wr1");

    access(0, 1, 0, 32'hFFE, 32'hCAFE_BABE, 9, 32'h0, "wwrap");
    exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    for (int k = 0; k < 4; k++)
      check($sformatf("wwrap addr%0d", k), log_addr[base + k], exp_a[k]);
    access(0, 0, 0, 32'hFFE, 32'h0, 9, 32'hCAFE_BABE, "wrwrap");
    access(0, 0, 1, 32'h001, 32'h0, 3, 32'h0000_00CA, "brwrap");
    check("hold rdata1", rdata1, 32'h1122_3344);

    access(1, 1, 0, 32'h20, 32'hAABB_CCDD, 9, 32'h0, "pre");
    @(negedge clk);
    base = log_n;
    req0 = 1; we0 = 1; byte0 = 0; addr0 = 32'h20; wdata0 = 32'h1122_3344;
    repeat (5) @(posedge clk);
    #1;
    check("mid byte2 addr", mem_addr, 32'h22);
    check("mid byte2 we", mem_we, 1);
    rst_n = 0;
    req0 = 0;
    #1;
    check("midrst ack0", ack0, 0);
    check("midrst busy", busy, 0);
    check("midrst we", mem_we, 0);
    check("midrst addr", mem_addr, 0);
    check("midrst wdata", mem_wdata, 0);
    check("midrst rdata0", rdata0, 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst no_ack", {ack0, ack1}, 0);
    end
    check("midrst nstrobe", log_n - base, 2);
    rst_n = 1;
    access(1, 0, 0, 32'h20, 32'h0, 9, 32'hAABB_3344, "rst_rd");

    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    req0 = 1; we0 = 0; byte0 = 1; addr0 = 32'h64;
    req1 = 1; we1 = 0; byte1 = 1; addr1 = 32'h10;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 === 1'b1) begin
        check("tie rdata0", rdata0, 32'hA5);
        seq[n] = 0;
        n++;
      end else if (ack1 === 1'b1) begin
        check("tie rdata1", rdata1, 32'h44);
        seq[n] = 1;
        n++;
      end
    end
    req0 = 0;
    req1 = 0;
    check("tie count", n, 4);
    for (int k = 0; k < n; k++) begin
`ifdef DMEM_ARB_RR_EN
      check($sformatf("tie grant%0d", k), seq[k], k % 2);
`else
      check($sformatf("tie grant%0d", k), seq[k], 0);
`endif
    end

    repeat (3) @(negedge clk);
    check("monitor", mon_errs, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
